// File: rtl/wam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wam_pkg
// Brief    : Shared widths, board size and judge state type for whack-a-mole.
// Revision : 1.0 - initial release
// ============================================================================
package wam_pkg;

    localparam int NUM_LIGHTS = 9;
    localparam int POS_W      = 4;
    localparam int SCORE_W    = 6;
    localparam int LIVES_W    = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MOLE = 3'd1,
        ARMED     = 3'd2,
        WHACKED   = 3'd3,
        DONE      = 3'd4
    } hj_state_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hit_judge_if.sv
`default_nettype none
// ============================================================================
// Module   : hit_judge_if
// Brief    : Game control, mole/key events and score outputs of hit_judge.
// Revision : 1.0 - initial release
// ============================================================================
interface hit_judge_if;
    import wam_pkg::*;

    logic               start;
    logic               active;
    logic               use_points;
    logic               use_lives;
    logic [SCORE_W-1:0] max_hits;
    logic [LIVES_W-1:0] total_lives;
    logic               light_change;
    logic [POS_W-1:0]   light_pos;
    logic               key_down;
    logic [POS_W-1:0]   key_pressed;
    logic [SCORE_W-1:0] total_points;
    logic [LIVES_W-1:0] lives_left;
    logic [SCORE_W-1:0] window_count;
    logic               hit;
    logic               miss;
    logic               game_over;

    modport master (
        output start, active, use_points, use_lives, max_hits, total_lives,
               light_change, light_pos, key_down, key_pressed,
        input  total_points, lives_left, window_count, hit, miss, game_over
    );

    modport slave (
        input  start, active, use_points, use_lives, max_hits, total_lives,
               light_change, light_pos, key_down, key_pressed,
        output total_points, lives_left, window_count, hit, miss, game_over
    );

endinterface
`default_nettype wire

// File: rtl/hit_judge_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Brief    : Registered rising-edge detector; rise pulses one cycle per 0->1.
// Revision : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      rise
);

    logic r_q;
    logic r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_q    <= d;
            r_rise <= d & ~r_q;
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/hit_judge.sv
`default_nettype none
// ============================================================================
// Module   : hit_judge
// Brief    : Judges hit/miss per mole window; keeps score, lives, window count.
// Revision : 1.0 - initial release
// ============================================================================
module hit_judge
    import wam_pkg::*;
(
    input  wire logic  CLOCK_50,
    input  wire logic  reset,
    hit_judge_if.slave bus
);

    hj_state_t          r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_points, w_points_nxt;
    logic [SCORE_W-1:0] r_windows, w_windows_nxt;
    logic [LIVES_W-1:0] r_lives, w_lives_nxt;
    logic [POS_W-1:0]   r_mole, w_mole_nxt;
    logic               r_hit, w_hit_nxt;
    logic               r_miss, w_miss_nxt;
    logic               w_key_rise;
    logic               w_valid_lc;
    logic               w_match;
    logic               w_end;
    logic               w_in_game;

    rise_detect u_key_rise (
        .clk  (CLOCK_50),
        .rst  (reset),
        .d    (bus.key_down),
        .rise (w_key_rise)
    );

    assign w_valid_lc = bus.light_change && (bus.light_pos < POS_W'(NUM_LIGHTS));
    // Compared against the mole latched before this edge, so a key arriving
    // with the closing strobe still scores against the outgoing mole.
    assign w_match    = w_key_rise && (bus.key_pressed == r_mole);
    assign w_end      = (bus.use_points && (r_windows == bus.max_hits)) ||
                        (bus.use_lives && (r_lives == '0));
    assign w_in_game  = (r_state == WAIT_MOLE) || (r_state == ARMED) || (r_state == WHACKED);

    always_comb begin
        w_state_nxt   = r_state;
        w_points_nxt  = r_points;
        w_windows_nxt = r_windows;
        w_lives_nxt   = r_lives;
        w_mole_nxt    = r_mole;
        w_hit_nxt     = 1'b0;
        w_miss_nxt    = 1'b0;
        if (bus.start) begin
            w_points_nxt  = '0;
            w_windows_nxt = '0;
            w_lives_nxt   = bus.total_lives;
            w_state_nxt   = WAIT_MOLE;
        end else if (bus.active) begin
            case (r_state)
                WAIT_MOLE: begin
                    if (w_valid_lc) begin
                        w_mole_nxt  = bus.light_pos;
                        w_state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (w_match) begin
                        w_points_nxt = sat_inc(r_points);
                        w_hit_nxt    = 1'b1;
                        w_state_nxt  = WHACKED;
                    end
                    if (w_valid_lc) begin
                        if (!w_match) begin
                            w_miss_nxt = 1'b1;
                            if (bus.use_lives && (r_lives != '0))
                                w_lives_nxt = r_lives - LIVES_W'(1);
                        end
                        w_windows_nxt = sat_inc(r_windows);
                        w_mole_nxt    = bus.light_pos;
                        w_state_nxt   = ARMED;
                    end
                end
                WHACKED: begin
                    if (w_valid_lc) begin
                        w_windows_nxt = sat_inc(r_windows);
                        w_mole_nxt    = bus.light_pos;
                        w_state_nxt   = ARMED;
                    end
                end
                default: ;
            endcase
            // End condition uses pre-edge counts; this cycle's events still land.
            if (w_in_game && w_end)
                w_state_nxt = DONE;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= IDLE;
            r_points  <= '0;
            r_windows <= '0;
            r_lives   <= '0;
            r_mole    <= '0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_points  <= w_points_nxt;
            r_windows <= w_windows_nxt;
            r_lives   <= w_lives_nxt;
            r_mole    <= w_mole_nxt;
            r_hit     <= w_hit_nxt;
            r_miss    <= w_miss_nxt;
        end
    end

    assign bus.total_points = r_points;
    assign bus.window_count = r_windows;
    assign bus.lives_left   = r_lives;
    assign bus.hit          = r_hit;
    assign bus.miss         = r_miss;
    assign bus.game_over    = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_hit_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_judge
// Brief    : Self-checking bench for hit_judge: vector table, directed games, random play.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hit_judge;
    import wam_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hit_judge_if bus();

    hit_judge dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int hits_seen   = 0;
    int misses_seen = 0;

    // Reference game: flags describe "in a game", "finished", "a mole is up",
    // "current mole already whacked"; kd1/kd2 are key_down one and two cycles back.
    int m_pts = 0, m_lives = 0, m_win = 0, m_mole = 0;
    bit m_hit = 0, m_miss = 0, m_playing = 0, m_done = 0, m_have_mole = 0, m_whacked = 0;
    bit kd1 = 0, kd2 = 0;

    typedef struct {
        int st, act, up, ul, mh, tl, lc, lp, kd, kp;
        int e_pts, e_lives, e_win, e_hit, e_miss, e_go;
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void model_step();
        bit rise, was_whacked, ended, vlc;
        rise = kd1 && !kd2;
        kd2  = kd1;
        kd1  = bus.key_down;
        if (reset) begin
            m_pts = 0; m_lives = 0; m_win = 0; m_mole = 0;
            m_hit = 0; m_miss = 0; m_playing = 0; m_done = 0;
            m_have_mole = 0; m_whacked = 0; kd1 = 0; kd2 = 0;
        end else begin
            m_hit  = 0;
            m_miss = 0;
            if (bus.start) begin
                m_pts = 0; m_win = 0; m_lives = int'(bus.total_lives);
                m_playing = 1; m_done = 0; m_have_mole = 0; m_whacked = 0;
            end else if (bus.active && m_playing && !m_done) begin
                ended = (bus.use_points && m_win == int'(bus.max_hits)) ||
                        (bus.use_lives && m_lives == 0);
                vlc   = bus.light_change && int'(bus.light_pos) < NUM_LIGHTS;
                if (!m_have_mole) begin
                    if (vlc) begin
                        m_mole = int'(bus.light_pos);
                        m_have_mole = 1;
                    end
                end else begin
                    was_whacked = m_whacked;
                    if (!was_whacked && rise && int'(bus.key_pressed) == m_mole) begin
                        m_pts     = (m_pts < 63) ? m_pts + 1 : 63;
                        m_hit     = 1;
                        m_whacked = 1;
                    end
                    if (vlc) begin
                        if (!was_whacked && !m_hit) begin
                            m_miss = 1;
                            if (bus.use_lives && m_lives > 0) m_lives--;
                        end
                        m_win     = (m_win < 63) ? m_win + 1 : 63;
                        m_mole    = int'(bus.light_pos);
                        m_whacked = 0;
                    end
                end
                if (ended) m_done = 1;
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        hits_seen   += int'(bus.hit);
        misses_seen += int'(bus.miss);
        chk("model.total_points", int'(bus.total_points), m_pts);
        chk("model.lives_left",   int'(bus.lives_left),   m_lives);
        chk("model.window_count", int'(bus.window_count), m_win);
        chk("model.hit",          int'(bus.hit),          int'(m_hit));
        chk("model.miss",         int'(bus.miss),         int'(m_miss));
        chk("model.game_over",    int'(bus.game_over),    int'(m_done));
    endtask

    task automatic strobe(input int pos);
        bus.light_change = 1'b1;
        bus.light_pos    = POS_W'(pos);
        tick();
        bus.light_change = 1'b0;
    endtask

    task automatic press(input int key, input int hold);
        bus.key_down    = 1'b1;
        bus.key_pressed = POS_W'(key);
        repeat (hold) tick();
        bus.key_down = 1'b0;
        tick();
    endtask

    task automatic do_start(input bit up, input bit ul, input int mh, input int tl);
        bus.use_points  = up;
        bus.use_lives   = ul;
        bus.max_hits    = SCORE_W'(mh);
        bus.total_lives = LIVES_W'(tl);
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        int seq[3];
        //            st act up ul mh tl lc lp kd kp | pts lv win hit miss go
        tbl[0]  = '{1, 1, 0, 1, 0, 2, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 0, 2, 1, 3, 0, 0,   0, 2, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 0, 2, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 1, 0, 2, 1, 5, 0, 0,   0, 1, 1, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 1, 0, 2, 1, 12, 0, 0,  0, 1, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 1, 0, 2, 1, 0, 0, 0,   0, 0, 2, 0, 1, 0};
        tbl[6]  = '{0, 1, 0, 1, 0, 2, 0, 0, 0, 0,   0, 0, 2, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 1, 0, 2, 1, 1, 0, 0,   0, 0, 2, 0, 0, 1};
        tbl[8]  = '{1, 1, 0, 1, 0, 3, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0};
        tbl[9]  = '{1, 1, 1, 0, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 1, 0, 2, 0, 1, 2, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 2, 0, 0, 0, 1, 2,   0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 1, 0, 2, 0, 0, 0, 1, 2,   1, 0, 0, 1, 0, 0};
        tbl[13] = '{0, 1, 1, 0, 2, 0, 1, 6, 0, 0,   1, 0, 1, 0, 0, 0};
        tbl[14] = '{0, 0, 1, 0, 2, 0, 0, 0, 1, 6,   1, 0, 1, 0, 0, 0};
        tbl[15] = '{0, 0, 1, 0, 2, 0, 0, 0, 1, 6,   1, 0, 1, 0, 0, 0};
        tbl[16] = '{0, 1, 1, 0, 2, 0, 0, 0, 1, 6,   1, 0, 1, 0, 0, 0};
        tbl[17] = '{0, 1, 1, 0, 2, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0};
        tbl[18] = '{0, 1, 1, 0, 2, 0, 0, 0, 1, 3,   1, 0, 1, 0, 0, 0};
        tbl[19] = '{0, 1, 1, 0, 2, 0, 0, 0, 1, 3,   1, 0, 1, 0, 0, 0};
        tbl[20] = '{0, 1, 1, 0, 2, 0, 1, 7, 0, 0,   1, 0, 2, 0, 1, 0};
        tbl[21] = '{0, 1, 1, 0, 2, 0, 0, 0, 0, 0,   1, 0, 2, 0, 0, 1};

        reset = 1'b1;
        bus.start = 1'b0; bus.active = 1'b1; bus.use_points = 1'b0; bus.use_lives = 1'b0;
        bus.max_hits = '0; bus.total_lives = '0; bus.light_change = 1'b0;
        bus.light_pos = '0; bus.key_down = 1'b0; bus.key_pressed = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset.total_points", int'(bus.total_points), 0);
        chk("reset.lives_left",   int'(bus.lives_left),   0);
        chk("reset.window_count", int'(bus.window_count), 0);
        chk("reset.game_over",    int'(bus.game_over),    0);

        for (int i = 0; i < 22; i++) begin
            bus.start        = 1'(tbl[i].st);
            bus.active       = 1'(tbl[i].act);
            bus.use_points   = 1'(tbl[i].up);
            bus.use_lives    = 1'(tbl[i].ul);
            bus.max_hits     = SCORE_W'(tbl[i].mh);
            bus.total_lives  = LIVES_W'(tbl[i].tl);
            bus.light_change = 1'(tbl[i].lc);
            bus.light_pos    = POS_W'(tbl[i].lp);
            bus.key_down     = 1'(tbl[i].kd);
            bus.key_pressed  = POS_W'(tbl[i].kp);
            tick();
            chk($sformatf("tbl%0d.total_points", i), int'(bus.total_points), tbl[i].e_pts);
            chk($sformatf("tbl%0d.lives_left", i),   int'(bus.lives_left),   tbl[i].e_lives);
            chk($sformatf("tbl%0d.window_count", i), int'(bus.window_count), tbl[i].e_win);
            chk($sformatf("tbl%0d.hit", i),          int'(bus.hit),          tbl[i].e_hit);
            chk($sformatf("tbl%0d.miss", i),         int'(bus.miss),         tbl[i].e_miss);
            chk($sformatf("tbl%0d.game_over", i),    int'(bus.game_over),    tbl[i].e_go);
        end
        bus.start = 1'b0; bus.active = 1'b1; bus.light_change = 1'b0; bus.key_down = 1'b0;

        // Points game: three whacked moles, fourth strobe closes the last window.
        do_start(1, 0, 3, 0);
        hits_seen = 0; misses_seen = 0;
        seq = '{2, 5, 7};
        foreach (seq[k]) begin
            strobe(seq[k]);
            press(seq[k], 2);
        end
        strobe(0);
        tick();
        chk("points.total_points", int'(bus.total_points), 3);
        chk("points.window_count", int'(bus.window_count), 3);
        chk("points.game_over",    int'(bus.game_over),    1);
        chk("points.misses_seen",  misses_seen,            0);
        chk("points.hits_seen",    hits_seen,              3);

        // Lives game: unhit windows drain lives.
        do_start(0, 1, 0, 2);
        strobe(1);
        chk("lives.first_lives", int'(bus.lives_left), 2);
        strobe(4);
        chk("lives.miss1", int'(bus.miss), 1);
        chk("lives.lives1", int'(bus.lives_left), 1);
        strobe(8);
        chk("lives.miss2", int'(bus.miss), 1);
        chk("lives.lives0", int'(bus.lives_left), 0);
        chk("lives.not_over_yet", int'(bus.game_over), 0);
        tick();
        chk("lives.game_over", int'(bus.game_over), 1);

        // Held key across a new mole at the same position scores once.
        do_start(0, 0, 0, 0);
        hits_seen = 0;
        strobe(4);
        bus.key_down = 1'b1; bus.key_pressed = POS_W'(4);
        repeat (5) tick();
        strobe(4);
        repeat (5) tick();
        bus.key_down = 1'b0;
        tick();
        chk("held.total_points", int'(bus.total_points), 1);
        chk("held.hits_seen",    hits_seen,              1);

        // Matching key and closing strobe in the same cycle.
        bus.key_down = 1'b1; bus.key_pressed = POS_W'(4);
        tick();
        strobe(6);
        chk("simul.hit",          int'(bus.hit),          1);
        chk("simul.miss",         int'(bus.miss),         0);
        chk("simul.window_count", int'(bus.window_count), 2);
        bus.key_down = 1'b0;
        tick();
        press(3, 2);
        chk("wrongkey.total_points", int'(bus.total_points), 2);
        press(6, 2);
        chk("newmole.total_points", int'(bus.total_points), 3);

        // Reset in the middle of a game.
        do_start(0, 0, 0, 0);
        for (int p = 0; p < 5; p++) begin
            strobe(p);
            press(p, 2);
        end
        strobe(8);
        chk("prereset.total_points", int'(bus.total_points), 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset.total_points", int'(bus.total_points), 0);
        chk("midreset.window_count", int'(bus.window_count), 0);
        chk("midreset.lives_left",   int'(bus.lives_left),   0);
        chk("midreset.game_over",    int'(bus.game_over),    0);
        strobe(2);
        press(2, 2);
        chk("idle.total_points", int'(bus.total_points), 0);

        // Zero-life and zero-window games end right after the start cycle.
        do_start(0, 1, 0, 0);
        chk("zerolives.after_start", int'(bus.game_over), 0);
        tick();
        chk("zerolives.game_over", int'(bus.game_over), 1);
        do_start(0, 1, 0, 5);
        chk("restart.lives_left", int'(bus.lives_left), 5);
        chk("restart.game_over",  int'(bus.game_over),  0);
        do_start(1, 0, 0, 0);
        tick();
        chk("zerohits.game_over", int'(bus.game_over), 1);

        // Random play against the reference game.
        do_start(1, 1, 4, 3);
        for (int c = 0; c < 800; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            bus.start = ($urandom_range(0, 59) == 0);
            if (bus.start) begin
                bus.use_points  = 1'($urandom_range(0, 1));
                bus.use_lives   = 1'($urandom_range(0, 1));
                bus.max_hits    = SCORE_W'($urandom_range(0, 6));
                bus.total_lives = LIVES_W'($urandom_range(0, 4));
            end
            bus.active       = ($urandom_range(0, 9) != 0);
            bus.light_change = ($urandom_range(0, 4) == 0);
            bus.light_pos    = POS_W'($urandom_range(0, 11));
            if ($urandom_range(0, 2) == 0) begin
                if (!bus.key_down) begin
                    bus.key_down    = 1'b1;
                    bus.key_pressed = ($urandom_range(0, 1) == 1) ? POS_W'(m_mole)
                                                                  : POS_W'($urandom_range(0, 8));
                end else begin
                    bus.key_down = 1'b0;
                end
            end
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
